// File: rtl/hex_line_parser_if.sv
// Byte-in / record-out bundle between a uart_rx byte source and the hex line parser.
// The slave modport is the parser side; master is the byte source plus the record consumer.
interface hex_line_parser_if #(
    parameter int WIDTH      = 28,
    parameter int MAX_DIGITS = WIDTH / 4,
    parameter int DIGITS_W   = $clog2(MAX_DIGITS + 1)
);
    logic [7:0]          data;
    logic                data_strobe;
    logic [WIDTH-1:0]    word;
    logic                word_strobe;
    logic [DIGITS_W-1:0] digits;
    logic                error_strobe;

    modport master (
        output data,
        output data_strobe,
        input  word,
        input  word_strobe,
        input  digits,
        input  error_strobe
    );

    modport slave (
        input  data,
        input  data_strobe,
        output word,
        output word_strobe,
        output digits,
        output error_strobe
    );
endinterface

// File: rtl/hex_line_parser.sv
// Rebuilds fixed-width hex records (e.g. "A1 2345F\r\n") from a received ASCII byte stream,
// emitting one right-aligned word per good line and an error pulse per malformed line.
module hex_line_parser #(
    parameter int WIDTH      = 28,
    parameter int MAX_DIGITS = WIDTH / 4
) (
    input  logic              clk,
    input  logic              reset,
    hex_line_parser_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CL_DIGIT = 2'd0,
        CL_SEP   = 2'd1,
        CL_TERM  = 2'd2,
        CL_BAD   = 2'd3
    } char_class_t;

    function automatic char_class_t classify(input logic [7:0] c);
        char_class_t cl;
        if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
            (c >= 8'h61 && c <= 8'h66)) begin
            cl = CL_DIGIT;
        end else if (c == 8'h20 || c == 8'h09) begin
            cl = CL_SEP;
        end else if (c == 8'h0D || c == 8'h0A) begin
            cl = CL_TERM;
        end else begin
            cl = CL_BAD;
        end
        return cl;
    endfunction

    // Letters share the low nibble pattern 1..6 in both cases, so one offset covers A-F and a-f.
    function automatic logic [3:0] nibble(input logic [7:0] c);
        logic [3:0] n;
        if (c <= 8'h39) begin
            n = c[3:0];
        end else begin
            n = c[3:0] + 4'd9;
        end
        return n;
    endfunction

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] shift_q,  shift_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] word_q,   word_d;
    logic [CNT_W-1:0] digits_q, digits_d;
    logic             word_stb_q, word_stb_d;
    logic             err_stb_q,  err_stb_d;
    char_class_t      cls_s;
    logic [3:0]       nib_s;

    // State and output registers; reset clears any partial line without a strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            word_q     <= '0;
            digits_q   <= '0;
            word_stb_q <= 1'b0;
            err_stb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            word_q     <= word_d;
            digits_q   <= digits_d;
            word_stb_q <= word_stb_d;
            err_stb_q  <= err_stb_d;
        end
    end

    // Next-state and output decode for one strobed byte.
    always_comb begin
        cls_s      = classify(bus.data);
        nib_s      = nibble(bus.data);
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        word_d     = word_q;
        digits_d   = digits_q;
        word_stb_d = 1'b0;
        err_stb_d  = 1'b0;

        if (bus.data_strobe) begin
            case (state_q)
                IDLE: begin
                    case (cls_s)
                        CL_DIGIT: begin
                            shift_d = {{(WIDTH-4){1'b0}}, nib_s};
                            count_d = CNT_W'(1);
                            state_d = ACCUM;
                        end
                        CL_BAD:  state_d = DISCARD;
                        default: state_d = IDLE;
                    endcase
                end
                ACCUM: begin
                    case (cls_s)
                        CL_DIGIT: begin
                            if (count_q == MAX_CNT) begin
                                state_d = DISCARD;
                            end else begin
                                shift_d = {shift_q[WIDTH-5:0], nib_s};
                                count_d = count_q + CNT_W'(1);
                            end
                        end
                        CL_TERM: begin
                            word_d     = shift_q;
                            digits_d   = count_q;
                            word_stb_d = 1'b1;
                            shift_d    = '0;
                            count_d    = '0;
                            state_d    = IDLE;
                        end
                        CL_BAD:  state_d = DISCARD;
                        default: state_d = ACCUM;
                    endcase
                end
                DISCARD: begin
                    if (cls_s == CL_TERM) begin
                        err_stb_d = 1'b1;
                        shift_d   = '0;
                        count_d   = '0;
                        state_d   = IDLE;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                default: begin
                    shift_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign bus.word         = word_q;
    assign bus.digits       = digits_q;
    assign bus.word_strobe  = word_stb_q;
    assign bus.error_strobe = err_stb_q;
endmodule

// File: tb/tb_hex_line_parser.sv
// Directed bench for hex_line_parser: a line-level reference model predicts every output cycle,
// and literal expectations per scenario pin both the model and the strobe counts.
module tb_hex_line_parser;
    localparam int WIDTH = 28;
    localparam int MAXD  = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    hex_line_parser_if #(.WIDTH(WIDTH)) bus ();

    hex_line_parser #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_w   = 0;
    int n_e   = 0;
    bit mon_en = 1'b0;

    // Model: next-cycle predictions (set by driver) and the registered expectation.
    logic [WIDTH-1:0] m_nxt_word   = '0;
    logic [2:0]       m_nxt_digits = '0;
    logic             m_nxt_wstb   = 1'b0;
    logic             m_nxt_estb   = 1'b0;
    logic [WIDTH-1:0] exp_word     = '0;
    logic [2:0]       exp_digits   = '0;
    logic             exp_wstb     = 1'b0;
    logic             exp_estb     = 1'b0;
    byte              line_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_hex(input byte c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hex_val(input byte c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return int'(c) - 87;
    endfunction

    // Judge a whole line once its terminator arrives.
    task automatic model_byte(input byte c);
        int  nd;
        bit  bad;
        logic [WIDTH-1:0] val;
        m_nxt_wstb = 1'b0;
        m_nxt_estb = 1'b0;
        if (c == 8'h0D || c == 8'h0A) begin
            nd  = 0;
            bad = 1'b0;
            val = '0;
            foreach (line_q[i]) begin
                if (is_hex(line_q[i])) begin
                    nd++;
                    if (nd <= MAXD) val = (val << 4) | WIDTH'(hex_val(line_q[i]));
                end else if (line_q[i] != 8'h20 && line_q[i] != 8'h09) begin
                    bad = 1'b1;
                end
            end
            if (bad || nd > MAXD) begin
                m_nxt_estb = 1'b1;
            end else if (nd > 0) begin
                m_nxt_wstb   = 1'b1;
                m_nxt_word   = val;
                m_nxt_digits = 3'(nd);
            end
            line_q.delete();
        end else begin
            line_q.push_back(c);
        end
    endtask

    // One-cycle output latency of the model.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_word   <= '0;
            exp_digits <= '0;
            exp_wstb   <= 1'b0;
            exp_estb   <= 1'b0;
        end else begin
            exp_word   <= m_nxt_word;
            exp_digits <= m_nxt_digits;
            exp_wstb   <= m_nxt_wstb;
            exp_estb   <= m_nxt_estb;
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("word_strobe", 32'(bus.word_strobe), 32'(exp_wstb));
                chk("error_strobe", 32'(bus.error_strobe), 32'(exp_estb));
                chk("word", 32'(bus.word), 32'(exp_word));
                if (exp_wstb) chk("digits", 32'(bus.digits), 32'(exp_digits));
                chk("strobes_exclusive", 32'(bus.word_strobe & bus.error_strobe), 32'd0);
                if (bus.word_strobe)  n_w++;
                if (bus.error_strobe) n_e++;
            end
        end
    end

    task automatic send(input byte c);
        bus.data        = c;
        bus.data_strobe = 1'b1;
        model_byte(c);
        @(negedge clk);
    endtask

    // Idle cycles carry junk on data to show unstrobed bytes are ignored.
    task automatic idle(input int n);
        bus.data_strobe = 1'b0;
        m_nxt_wstb      = 1'b0;
        m_nxt_estb      = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.data = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            if (gap > 0) idle(gap);
        end
        idle(3);
    endtask

    task automatic pin(input string name, input int w0, input int e0, input int dw, input int de,
                       input logic [WIDTH-1:0] word_exp);
        chk({name, "_word_count"}, 32'(n_w - w0), 32'(dw));
        chk({name, "_err_count"}, 32'(n_e - e0), 32'(de));
        chk({name, "_model_word"}, 32'(m_nxt_word), 32'(word_exp));
    endtask

    initial begin
        int w0;
        int e0;
        bus.data        = 8'h00;
        bus.data_strobe = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(2);
        chk("reset_word", 32'(bus.word), 32'd0);
        chk("reset_digits", 32'(bus.digits), 32'd0);

        w0 = n_w; e0 = n_e;
        send_str("A1 2345F\r\n", 15);
        pin("spaced", w0, e0, 1, 0, 28'hA12345F);

        w0 = n_w; e0 = n_e;
        send("a"); send("b"); send("\n");
        chk("b2b_latency_strobe", 32'(bus.word_strobe), 32'd1);
        chk("b2b_latency_word", 32'(bus.word), 32'h00000AB);
        chk("b2b_latency_digits", 32'(bus.digits), 32'd2);
        idle(3);
        pin("b2b", w0, e0, 1, 0, 28'h00000AB);

        w0 = n_w; e0 = n_e;
        send_str("123456789\r\n", 0);
        pin("overflow", w0, e0, 0, 1, 28'h00000AB);

        w0 = n_w; e0 = n_e;
        send_str("12G4\r\n7\r\n", 1);
        pin("bad_then_good", w0, e0, 1, 1, 28'h0000007);
        chk("one_digit_digits", 32'(m_nxt_digits), 32'd1);

        w0 = n_w; e0 = n_e;
        send_str("\r\n\r\n   \n", 0);
        pin("blank", w0, e0, 0, 0, 28'h0000007);

        w0 = n_w; e0 = n_e;
        send_str("abcdef0\r\n1\t2 3\n", 0);
        pin("full_and_sep", w0, e0, 2, 0, 28'h0000123);

        w0 = n_w; e0 = n_e;
        send_str("#\n", 0);
        pin("bad_first", w0, e0, 0, 1, 28'h0000123);

        w0 = n_w; e0 = n_e;
        send("D"); send("E"); send("A"); send("D");
        idle(2);
        reset = 1'b0;
        line_q.delete();
        m_nxt_word   = '0;
        m_nxt_digits = '0;
        idle(3);
        chk("in_reset_word", 32'(bus.word), 32'd0);
        reset = 1'b1;
        idle(2);
        send_str("BEEF\r\n", 0);
        pin("reset_mid_line", w0, e0, 1, 0, 28'h000BEEF);
        chk("beef_digits", 32'(bus.digits), 32'd4);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hex_line_parser.md
# hex_line_parser

Receive-side counterpart to the sensor-report printer: consumes the ASCII byte stream from a `uart_rx` instance and rebuilds the fixed-width hex records that the transmitter prints, for example `A1 2345F\r\n`. Emits one parallel word per completed line, plus an error pulse for malformed lines. Sits between `uart_rx` and a record consumer such as a `fifo` or a host-side test harness on the FPGA.

## Interface
- `WIDTH`, 28: record width in bits; must be a multiple of 4.
- `MAX_DIGITS`, WIDTH/4: maximum hex digits accepted per line.
- `clk`  in  1  system clock (48 MHz in the demo top).
- `reset`  in  1  asynchronous, active-low reset; all state clears while low.
- `data`  in  8  received byte from `uart_rx`.
- `data_strobe`  in  1  one-cycle pulse; `data` is valid in that cycle.
- `word`  out  WIDTH  last parsed record, right-aligned and zero-extended; holds its value between strobes.
- `word_strobe`  out  1  one-cycle pulse; `word` is valid in the same cycle.
- `digits`  out  $clog2(MAX_DIGITS+1)  number of hex digits in the line just emitted; valid with `word_strobe`.
- `error_strobe`  out  1  one-cycle pulse when a line is rejected.

## Operation
- Character classes:
  - DIGIT: `0`-`9`, `A`-`F`, `a`-`f`; nibble value 0-15.
  - SEP: space (0x20) or tab (0x09).
  - TERM: `\r` (0x0D) or `\n` (0x0A).
  - BAD: any other byte.
- Internal state: `shift[WIDTH-1:0]`, `count`, and FSM `state` ∈ {IDLE, ACCUM, DISCARD}.
- IDLE (line empty):
  - DIGIT: `shift` = nibble, `count` = 1, go to ACCUM.
  - SEP or TERM: ignored, stay in IDLE. Blank lines and `\r\n` pairs produce no output.
  - BAD: go to DISCARD.
- ACCUM:
  - DIGIT with `count` < MAX_DIGITS: `shift` = {shift[WIDTH-5:0], nibble}, `count` += 1.
  - DIGIT with `count` == MAX_DIGITS (overflow): go to DISCARD.
  - SEP: ignored. Separators may appear anywhere between digits and do not reset `count`.
  - TERM: `word` = `shift`, `digits` = `count`, pulse `word_strobe`, clear `shift` and `count`, go to IDLE.
  - BAD: go to DISCARD.
- DISCARD:
  - All bytes except TERM are ignored.
  - TERM: pulse `error_strobe`, clear `shift` and `count`, go to IDLE. The second byte of a `\r\n` pair then arrives in IDLE and is ignored.
- Lines with fewer than MAX_DIGITS digits are accepted. The value is right-aligned, so `5\r` gives `word` = 5 and `digits` = 1.
- `word_strobe` and `error_strobe` are never high in the same cycle.

## Timing
- Reset values (reset low):
  - `state` = IDLE.
  - `shift`, `count`, `word`, `digits` = 0.
  - `word_strobe`, `error_strobe` = 0.
- Latency: the output strobe goes high on the first rising `clk` edge after the cycle in which the TERM byte has `data_strobe` high. It lasts exactly one cycle.
- Back-to-back `data_strobe` on consecutive cycles must be accepted with no drops. Each strobed cycle is processed independently.
- `data` is sampled only when `data_strobe` is high. Bytes in non-strobed cycles are ignored.
- Reset asserted mid-line: the partial line is lost and no strobe is generated. The first byte after reset release is parsed from IDLE.
- No timeout: an unterminated line stays in ACCUM or DISCARD indefinitely.

## Test plan
- `A1 2345F\r\n` with bytes spaced 16 clocks apart -> exactly one `word_strobe`, `word` = 0xA12345F, `digits` = 7, no `error_strobe`.
- `ab\n` sent with `data_strobe` on 3 consecutive cycles -> `word` = 0x00000AB, `digits` = 2, strobe 1 cycle after the `\n` cycle.
- `123456789\r\n` (9 digits, MAX_DIGITS = 7) -> one `error_strobe`, no `word_strobe`, `word` keeps its previous value.
- `12G4\r\n` followed by `7\r\n` -> one `error_strobe`, then `word_strobe` with `word` = 7, `digits` = 1.
- `\r\n\r\n   \n` -> no strobes at all.
- `DEAD` followed by reset low for 3 cycles, then `BEEF\r\n` -> no strobe during reset, `word` = 0 during reset, then `word` = 0x000BEEF with `digits` = 4.
